// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Types and default widths shared by the APB requester and APB slaves.
//   apb_state_e : bus phase encoding (IDLE / SETUP / ACCESS)
//   APB_ADDR_W  : default address width
//   APB_DATA_W  : default data width
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

endpackage : apb_pkg

// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
// Bundles the signals of the APB requester:
//   command port  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   response port : rsp_valid, rsp_write, rsp_rdata, rsp_error
//   APB bus       : psel, penable, paddr, pwrite, pwdata, pready, prdata
// Modports:
//   master : the requester's view (drives cmd_ready, rsp_*, APB request side)
//   slave  : the view of the command source / APB completer on the far side
// -----------------------------------------------------------------------------
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
) ();

    // Command port
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response port
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    // APB bus
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_error,
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_error,
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata
    );

endinterface : apb_master_if

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts consecutive ACCESS cycles in which the slave holds pready low and
// flags the cycle on which the TIMEOUT-th such cycle is being completed.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : zero the count (asserted when a transfer enters SETUP)
//   enable_i   : this cycle is an ACCESS cycle with pready low
//   expired_o  : the current low-pready cycle is the TIMEOUT-th one
// TIMEOUT = 0 disables the timer (expired_o never asserts).
// -----------------------------------------------------------------------------
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count low-pready cycles and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // The count already holds TIMEOUT-1 earlier low cycles, so this low cycle
    // is the TIMEOUT-th one and the transfer is aborted at its closing edge.
    always_comb begin
        if (TIMEOUT == 0) begin
            expired_o = 1'b0;
        end else begin
            expired_o = enable_i && (cnt_q == (CNT_MAX - CNT_ONE));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// APB requester. Accepts one read/write command at a time on a valid/ready
// port, runs a full IDLE -> SETUP -> ACCESS transfer, honours pready wait
// states and reports completion with a one-cycle response pulse. A wait-state
// timer aborts transfers to a slave that never raises pready.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high reset
//   bus   : apb_master_if.master (command, response and APB signals)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    apb_master_if.master bus
);

    apb_state_e        state_q;
    apb_state_e        state_d;

    logic              cmd_ready_q;
    logic              cmd_ready_d;
    logic              psel_q;
    logic              psel_d;
    logic              penable_q;
    logic              penable_d;
    logic [ADDR_W-1:0] paddr_q;
    logic [ADDR_W-1:0] paddr_d;
    logic              pwrite_q;
    logic              pwrite_d;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_write_q;
    logic              rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_error_q;
    logic              rsp_error_d;

    logic              accept_s;
    logic              done_s;
    logic              stall_s;
    logic              expired_s;

    // cmd_ready_q is only high in IDLE, so this is an IDLE handshake.
    assign accept_s = (state_q == IDLE) && bus.cmd_valid && cmd_ready_q;
    // pready only matters in ACCESS; elsewhere it is ignored.
    assign done_s   = (state_q == ACCESS) && bus.pready;
    assign stall_s  = (state_q == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (accept_s),
        .enable_i  (stall_s),
        .expired_o (expired_s)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= {ADDR_W{1'b0}};
            pwrite_q    <= 1'b0;
            pwdata_q    <= {DATA_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // expired_s is already gated by pready low, so a late pready
                // on the deciding cycle completes the transfer normally.
                if (done_s || expired_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs. Bus controls are decoded from
    // the next state so they line up with the state register.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = done_s || expired_s;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = 1'b0;

        // Address/direction/data are captured once and then held, which keeps
        // them stable through the transfer and quiet in IDLE.
        if (accept_s) begin
            paddr_d  = bus.cmd_addr;
            pwrite_d = bus.cmd_write;
            if (bus.cmd_write) begin
                pwdata_d = bus.cmd_wdata;
            end else begin
                pwdata_d = {DATA_W{1'b0}};
            end
        end else begin
            paddr_d  = paddr_q;
            pwrite_d = pwrite_q;
            pwdata_d = pwdata_q;
        end

        if (done_s) begin
            rsp_write_d = pwrite_q;
            rsp_error_d = 1'b0;
            if (pwrite_q) begin
                rsp_rdata_d = {DATA_W{1'b0}};
            end else begin
                rsp_rdata_d = bus.prdata;
            end
        end else if (expired_s) begin
            rsp_write_d = pwrite_q;
            rsp_rdata_d = {DATA_W{1'b0}};
            rsp_error_d = 1'b1;
        end else begin
            rsp_write_d = rsp_write_q;
            rsp_rdata_d = rsp_rdata_q;
            rsp_error_d = 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master. A small APB memory responder with a
// programmable number of wait states (or a hung mode) sits on the bus.
// Commands come from a vector table plus a few hand-written sequences; the
// expected response and its cycle are pushed to a scoreboard when a command
// is accepted and compared when rsp_valid appears.
// -----------------------------------------------------------------------------
module tb_apb_master;
    import apb_pkg::*;

    localparam int TMO = 16;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        int          waits;
        bit          hang;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          rsp_cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_wd;

    // ---------------- responder ----------------
    logic [31:0] mem [256];
    int acc_cnt = 0;
    int wait_cfg = 0;
    bit hang = 1'b0;
    bit preload_en = 1'b1;

    assign bus.pready = hang ? 1'b0 : (acc_cnt >= wait_cfg);
    assign bus.prdata = (bus.psel && bus.penable) ? mem[bus.paddr] : 32'hBAD0_BAD0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h05] <= 32'h5555_5555;
            mem[8'h22] <= 32'hCACA_CACA;
            mem[8'h30] <= 32'h7777_7777;
            mem[8'h31] <= 32'h3131_3131;
            mem[8'h40] <= 32'h4040_4040;
        end else if (bus.psel && bus.penable && bus.pready && bus.pwrite) begin
            mem[bus.paddr] <= bus.pwdata;
        end
        if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
        else if (!bus.penable) acc_cnt <= 0;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, required no response", cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (bus.rsp_write !== mon_e.w || bus.rsp_rdata !== mon_e.rdata ||
                        bus.rsp_error !== mon_e.err || cyc != mon_e.rsp_cyc) begin
                        errors++;
                        $display("FAIL rsp addr=%02h: got write=%0b rdata=%08h error=%0b cycle=%0d, required write=%0b rdata=%08h error=%0b cycle=%0d",
                                 mon_e.a, bus.rsp_write, bus.rsp_rdata, bus.rsp_error, cyc,
                                 mon_e.w, mon_e.rdata, mon_e.err, mon_e.rsp_cyc);
                    end
                end
                checks++;
                if (bus.cmd_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rsp_cmd_ready: got %0b, required 1", bus.cmd_ready);
                end
            end
            if (bus.psel === 1'b1 && sb_q.size() > 0) begin
                mon_e  = sb_q[0];
                mon_wd = mon_e.w ? mon_e.d : 32'h0;
                checks++;
                if (bus.paddr !== mon_e.a || bus.pwrite !== mon_e.w || bus.pwdata !== mon_wd ||
                    bus.penable !== (cyc != mon_e.acc + 1) || bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL apb_bus cycle %0d: got paddr=%02h pwrite=%0b pwdata=%08h penable=%0b cmd_ready=%0b, required paddr=%02h pwrite=%0b pwdata=%08h penable=%0b cmd_ready=0",
                             cyc, bus.paddr, bus.pwrite, bus.pwdata, bus.penable, bus.cmd_ready,
                             mon_e.a, mon_e.w, mon_wd, (cyc != mon_e.acc + 1));
                end
            end
        end
    end

    // ---------------- tasks ----------------
    task automatic issue(input vec_t v, input bit release_v, output int acc);
        int   n;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.w;
        bus.cmd_addr  = v.a;
        bus.cmd_wdata = v.d;
        wait_cfg      = v.waits;
        hang          = v.hang;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept_timeout addr=%02h: cmd_ready stayed %0b, required 1", v.a, bus.cmd_ready);
        end else begin
            e.w = v.w; e.a = v.a; e.d = v.d;
            e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc = acc;
            e.rsp_cyc = v.exp_err ? (acc + 2 + TMO) : (acc + 3 + v.waits);
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (release_v) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("FAIL %s ctrl: got psel=%0b penable=%0b pwrite=%0b rsp_valid=%0b rsp_write=%0b rsp_error=%0b cmd_ready=%0b, required 0000001",
                     name, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_write, bus.rsp_error, bus.cmd_ready);
        end
        checks++;
        if (bus.paddr !== 8'h00 || bus.pwdata !== 32'h0) begin
            errors++;
            $display("FAIL %s bus: got paddr=%02h pwdata=%08h, required 00 00000000", name, bus.paddr, bus.pwdata);
        end
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s rsp_rdata: got %08h, required 00000000", name, bus.rsp_rdata);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t tbl [13];
        vec_t bp0, bp1, rd40;
        int   acc1, acc2, dummy, n;

        //            w     addr   wdata          waits hang  exp_rdata      exp_err
        tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF,  0, 1'b0, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 8'h10, 32'h5A5A5A5A,  0, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 8'h22, 32'h00000000,  3, 1'b0, 32'hCACACACA, 1'b0};
        tbl[3]  = '{1'b0, 8'h05, 32'h00000000,  0, 1'b1, 32'h00000000, 1'b1};
        tbl[4]  = '{1'b1, 8'h05, 32'h12345678,  0, 1'b0, 32'h00000000, 1'b0};
        tbl[5]  = '{1'b0, 8'h05, 32'h00000000,  1, 1'b0, 32'h12345678, 1'b0};
        tbl[6]  = '{1'b1, 8'h30, 32'hA5A5A5A5, 15, 1'b0, 32'h00000000, 1'b0};
        tbl[7]  = '{1'b0, 8'h30, 32'h00000000, 15, 1'b0, 32'hA5A5A5A5, 1'b0};
        tbl[8]  = '{1'b1, 8'h31, 32'h0BADF00D, 16, 1'b0, 32'h00000000, 1'b1};
        tbl[9]  = '{1'b0, 8'h31, 32'h00000000,  0, 1'b0, 32'h31313131, 1'b0};
        tbl[10] = '{1'b1, 8'hFF, 32'hFFFFFFFF,  2, 1'b0, 32'h00000000, 1'b0};
        tbl[11] = '{1'b0, 8'hFF, 32'h00000000,  0, 1'b0, 32'hFFFFFFFF, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 32'h00000000,  2, 1'b0, 32'h00000000, 1'b0};
        bp0     = '{1'b1, 8'h01, 32'h00000011,  0, 1'b0, 32'h00000000, 1'b0};
        bp1     = '{1'b0, 8'h01, 32'h00000000,  0, 1'b0, 32'h00000011, 1'b0};
        rd40    = '{1'b0, 8'h40, 32'h00000000,  0, 1'b0, 32'h40404040, 1'b0};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_init");
        preload_en = 1'b0;
        reset = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i], 1'b1, dummy);
            drain();
        end

        // Two commands with cmd_valid held between them.
        issue(bp0, 1'b0, acc1);
        issue(bp1, 1'b1, acc2);
        drain();
        checks++;
        if (acc2 - acc1 != 3) begin
            errors++;
            $display("FAIL backpressure_spacing: got %0d cycles, required 3", acc2 - acc1);
        end

        // Reset while a waited write sits in ACCESS.
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h40;
        bus.cmd_wdata = 32'h99999999;
        wait_cfg = 5;
        hang = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.penable !== 1'b1) begin
            errors++;
            $display("FAIL reset_precondition: got penable=%0b, required 1", bus.penable);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset("reset_mid_access");
        reset = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_no_rsp: got %0d responses, required 0", n);
        end
        issue(rd40, 1'b1, dummy);
        drain();

        // Responder memory contents written through the bus.
        checks++;
        if (mem[8'h10] !== 32'hDEADBEEF || mem[8'h01] !== 32'h00000011) begin
            errors++;
            $display("FAIL mem_contents: got mem[10]=%08h mem[01]=%08h, required DEADBEEF 00000011",
                     mem[8'h10], mem[8'h01]);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_apb_master

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the team's APB bus toward slave peripherals such as the APB memory slave.
- Accepts single read/write commands on a valid/ready command port and runs one full IDLE→SETUP→ACCESS transfer per command.
- Honours pready wait states and returns read data or an error on a one-cycle response port.
- A wait-state timeout aborts transfers to a hung slave so the bus never locks up.

Parameters:
- ADDR_W, 8, width of paddr/cmd_addr.
- DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata.
- TIMEOUT, 16, maximum consecutive ACCESS cycles with pready low before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command (high only in IDLE).
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_write  out  1  echo of the completed command's direction.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_error  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.

Behaviour:
- Clocking and reset:
  - Single clock clk; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values: state=IDLE; psel, penable, pwrite, rsp_valid, rsp_write and rsp_error = 0; paddr, pwdata and rsp_rdata = 0; wait counter = 0; cmd_ready = 1 in the cycle after reset.
- States:
  - IDLE: cmd_ready=1, psel=0, penable=0.
    - On cmd_valid&&cmd_ready at edge N, capture addr/write/wdata into paddr/pwrite/pwdata and go to SETUP.
    - pwdata is loaded as 0 for reads.
  - SETUP (cycle N+1): psel=1, penable=0, cmd_ready=0. Unconditionally go to ACCESS.
  - ACCESS (cycle N+2 onward): psel=1, penable=1.
    - If pready=1 at an edge: if read, capture prdata into rsp_rdata; if write, set rsp_rdata to 0.
    - On that same pready edge: pulse rsp_valid the next cycle with rsp_error=0, drop psel and penable, return to IDLE.
    - If pready=0: stay in ACCESS and increment the wait counter.
- Timeout:
  - When TIMEOUT>0 and the wait counter reaches TIMEOUT with pready still 0 (i.e. after TIMEOUT low-pready ACCESS cycles), abort at that edge.
  - Abort drops psel/penable, pulses rsp_valid with rsp_error=1 and rsp_rdata=0, and returns to IDLE.
  - If pready=1 arrives on the deciding cycle, it wins and the transfer completes normally.
  - The wait counter clears on entry to SETUP.
- Latency and throughput:
  - Zero-wait transfer: accept at N, psel at N+1, penable at N+2, rsp_valid at N+3, cmd_ready high again at N+3.
  - Maximum rate is one transfer per 3 cycles. There is no back-to-back SETUP.
- Bus stability:
  - paddr, pwrite and pwdata are constant from SETUP through the end of ACCESS.
  - After completion they hold their last values; no toggling in IDLE.
- Response port: rsp_valid is exactly one cycle, with no backpressure. rsp_write/rsp_rdata/rsp_error are valid only with rsp_valid.
- Boundary cases:
  - cmd_valid while busy: ignored (cmd_ready=0); the requester holds it.
  - Reset asserted in any state: the next edge forces the reset values; no rsp_valid is produced for the killed transfer.
  - prdata is sampled only in ACCESS with pready=1; it is ignored otherwise.
  - pready is ignored outside ACCESS.
  - Wait counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), shared with the slave.
  - localparams APB_ADDR_W=8 and APB_DATA_W=32.
- One natural sub-module: apb_wait_timer.
  - Inputs: clear, enable (ACCESS && !pready).
  - Output: expired.
  - Parameter: TIMEOUT.

Test Plan:
- Write, zero wait: cmd write addr=0x10 wdata=0xDEADBEEF, responder pready=1 → psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_error=0; responder memory[0x10]=0xDEADBEEF.
- Read, 3 wait states: preload 0xCACACACA at 0x22, cmd read 0x22, pready low 3 ACCESS cycles → paddr stable throughout; rsp_valid at N+6 with rsp_rdata=0xCACACACA.
- Timeout: TIMEOUT=16, pready tied 0, read 0x05 → exactly 16 ACCESS cycles, then psel=0 and rsp_valid=1 with rsp_error=1, rsp_rdata=0; the next command is accepted normally.
- Back-pressure: cmd_valid held high with two commands (write 0x01=0x11, read 0x01) → cmd_ready low during the first transfer; the read returns 0x11; transfers are 3 cycles apart minimum.
- Reset mid-ACCESS: assert reset for 1 cycle during a waited write → all outputs at reset values next edge, no rsp_valid, cmd_ready=1 afterwards.
- Timeout race: pready rises on the 16th low-wait cycle boundary → normal completion with rsp_error=0.
